// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, display-enable,
// coordinate and end-of-line/frame strobes. Define VGA_FRAME_CNT_EN to add a 16-bit frame counter.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 1024,
  parameter int   H_FRONT   = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BACK    = 160,
  parameter int   V_VISIBLE = 768,
  parameter int   V_FRONT   = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BACK    = 29,
  parameter logic H_POL     = 1'b0,
  parameter logic V_POL     = 1'b0,
  parameter int   CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_end,
  output logic          frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Thresholds pre-sized to the counter width so every compare is width-matched.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [CW-1:0] x_q, y_q;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_end_q, line_end_d;
  logic          frame_end_q, frame_end_d;
  logic          h_wrap, v_wrap;

  // (h_q, v_q) is the position whose outputs are loaded on the next enabled edge.
  always_comb begin
    h_wrap      = (h_q == H_LAST);
    v_wrap      = h_wrap && (v_q == V_LAST);
    h_d         = h_wrap ? '0 : h_q + 1'b1;
    v_d         = v_q;
    if (v_wrap) begin
      v_d = '0;
    end else if (h_wrap) begin
      v_d = v_q + 1'b1;
    end
    de_d        = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    hsync_d     = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? H_POL : ~H_POL;
    vsync_d     = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? V_POL : ~V_POL;
    line_end_d  = h_wrap;
    frame_end_d = v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else if (en) begin
      h_q         <= h_d;
      v_q         <= v_d;
      x_q         <= h_q;
      y_q         <= v_q;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign x         = x_q;
  assign y         = y_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Counts completed frames; free-running 16-bit wrap.
  always_comb begin
    frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else if (en && v_wrap) begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule
